// File: rtl/spi_packet_receiver_pkg.sv
// Shared router definitions used by the SPI ingress stage.
//   - Destination port encodings.
//   - Header field positions inside the first received word.
//   - Receiver FSM state encoding.
//   - Header validity check.
package spi_packet_receiver_pkg;

  localparam logic [1:0] PORT0 = 2'b00;
  localparam logic [1:0] PORT1 = 2'b01;

  // The destination field is the top DEST_W bits of the header word.
  // DEST_MSB_OFS is the distance of its MSB below the word MSB.
  localparam int DEST_W       = 2;
  localparam int DEST_MSB_OFS = 0;

  // The length field occupies header bits [LEN_MSB:LEN_LSB].
  localparam int LEN_MSB = 3;
  localparam int LEN_LSB = 0;
  localparam int LEN_W   = LEN_MSB - LEN_LSB + 1;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    PRESENT,
    STROBE,
    DRAIN
  } state_t;

  // A header is accepted only for a routed port and a non-empty payload.
  function automatic logic hdr_valid(input logic [DEST_W-1:0] dest,
                                     input logic [LEN_W-1:0]  len);
    return ((dest == PORT0) || (dest == PORT1)) && (len != '0);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronizes the asynchronous SPI pins into the clk domain and derives
// single-cycle edge events.
//   clk, rst   : system clock, asynchronous active-high reset
//   sclk, mosi, cs_n : raw SPI pins
//   sclk_rise  : one-cycle pulse on a synchronized sclk rising edge
//   cs_fall    : one-cycle pulse on a synchronized cs_n falling edge
//   cs_rise    : one-cycle pulse on a synchronized cs_n rising edge
//   mosi_s     : synchronized mosi, aligned with sclk_rise
//   cs_s       : synchronized cs_n level
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic mosi,
  input  logic cs_n,
  output logic sclk_rise,
  output logic cs_fall,
  output logic cs_rise,
  output logic mosi_s,
  output logic cs_s
);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   sclk_prev;
  logic                   cs_prev;

  // The cs_n chain resets low rather than to the idle-high level: if reset
  // lands in the middle of a packet with cs_n still asserted, no falling edge
  // is seen afterwards, so the receiver waits for a genuinely new packet.
  // A high cs_n after reset only produces a rising edge, which IDLE ignores.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
      cs_prev   <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_rise = ~sclk_prev & sclk_sync[SYNC_STAGES-1];
  assign cs_fall   = cs_prev & ~cs_sync[SYNC_STAGES-1];
  assign cs_rise   = ~cs_prev & cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];

endmodule

// File: rtl/spi_packet_receiver.sv
// SPI mode-0 slave ingress stage. Deserializes MSB-first words, decodes a
// one-word header (destination + length) and hands each payload word to the
// port demultiplexer with a held selector and a one-cycle enable strobe.
// Malformed, aborted or overrun packets are dropped with a pkt_error pulse.
//   clk, rst   : system clock, asynchronous active-high reset
//   sclk, mosi, cs_n : SPI slave pins (asynchronous to clk)
//   selector   : destination port, updated only when a header is accepted
//   data_out   : current payload word
//   enable     : one-cycle strobe; demux samples selector/data_out here
//   busy       : high while a packet is framed (not IDLE)
//   pkt_done   : one-cycle pulse after the last enable of a valid packet
//   pkt_error  : one-cycle pulse on any dropped packet
module spi_packet_receiver
  import spi_packet_receiver_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  cs_n,
  output logic [DEST_W-1:0]     selector,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  enable,
  output logic                  busy,
  output logic                  pkt_done,
  output logic                  pkt_error
);

  localparam int BCW = $clog2(DATA_WIDTH);

  logic sclk_rise, cs_fall, cs_rise, mosi_s, cs_s;

  spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .mosi     (mosi),
    .cs_n     (cs_n),
    .sclk_rise(sclk_rise),
    .cs_fall  (cs_fall),
    .cs_rise  (cs_rise),
    .mosi_s   (mosi_s),
    .cs_s     (cs_s)
  );

  state_t                state, state_nxt;
  logic [BCW-1:0]        bit_cnt;
  logic [LEN_W-1:0]      remain;
  logic [DATA_WIDTH-2:0] shreg;
  logic [DATA_WIDTH-1:0] word;
  logic                  counting;
  logic                  word_done;
  logic                  load_hdr, load_data, dec_cnt, clr_bits;
  logic                  err_nxt, done_nxt;
  logic [DEST_W-1:0]     hdr_dest;
  logic [LEN_W-1:0]      hdr_len;

  // The word including the bit being shifted in this cycle, so a completed
  // word can be consumed in the same cycle its last edge is detected.
  assign word     = {shreg, mosi_s};
  assign hdr_dest = word[DATA_WIDTH-1-DEST_MSB_OFS -: DEST_W];
  assign hdr_len  = word[LEN_MSB:LEN_LSB];

  // Bits keep being counted in PRESENT/STROBE so an early next word is
  // recognised as an overrun; DRAIN and IDLE ignore the bus.
  assign counting  = (state == HEADER) || (state == PAYLOAD) ||
                     (state == PRESENT) || (state == STROBE);
  assign word_done = counting && sclk_rise && (bit_cnt == BCW'(DATA_WIDTH - 1));
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // cs_n rise is tested before word completion everywhere: an abort wins
  // over a word finishing in the same cycle.
  always_comb begin
    state_nxt = state;
    load_hdr  = 1'b0;
    load_data = 1'b0;
    dec_cnt   = 1'b0;
    clr_bits  = 1'b0;
    err_nxt   = 1'b0;
    done_nxt  = 1'b0;
    enable    = 1'b0;
    unique case (state)
      IDLE: begin
        if (cs_fall) begin
          clr_bits  = 1'b1;
          state_nxt = HEADER;
        end
      end
      HEADER: begin
        if (cs_rise) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else if (word_done) begin
          if (hdr_valid(hdr_dest, hdr_len)) begin
            load_hdr  = 1'b1;
            state_nxt = PAYLOAD;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = DRAIN;
          end
        end
      end
      PAYLOAD: begin
        if (cs_rise) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else if (word_done) begin
          load_data = 1'b1;
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (cs_rise) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else if (word_done) begin
          err_nxt   = 1'b1;
          state_nxt = DRAIN;
        end else begin
          state_nxt = STROBE;
        end
      end
      STROBE: begin
        // The strobe for the word already presented always completes.
        enable  = 1'b1;
        dec_cnt = 1'b1;
        if (cs_rise) begin
          state_nxt = IDLE;
          if (remain > LEN_W'(1)) begin
            err_nxt = 1'b1;
          end else begin
            done_nxt = 1'b1;
          end
        end else if (word_done) begin
          err_nxt   = 1'b1;
          state_nxt = DRAIN;
        end else if (remain == LEN_W'(1)) begin
          done_nxt  = 1'b1;
          state_nxt = DRAIN;
        end else begin
          state_nxt = PAYLOAD;
        end
      end
      DRAIN: begin
        if (cs_s) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= '0;
      remain    <= '0;
      selector  <= PORT0;
      data_out  <= '0;
      pkt_done  <= 1'b0;
      pkt_error <= 1'b0;
    end else begin
      pkt_done  <= done_nxt;
      pkt_error <= err_nxt;
      if (clr_bits) begin
        bit_cnt <= '0;
      end else if (counting && sclk_rise) begin
        bit_cnt <= word_done ? '0 : bit_cnt + BCW'(1);
      end
      if (load_hdr) begin
        selector <= hdr_dest;
        remain   <= hdr_len;
      end else if (dec_cnt) begin
        remain <= remain - LEN_W'(1);
      end
      if (load_data) begin
        data_out <= word;
      end
    end
  end

  // Shift register needs no reset: data_out only loads from a full word.
  always_ff @(posedge clk) begin
    if (sclk_rise) begin
      shreg <= word[DATA_WIDTH-2:0];
    end
  end

endmodule

// File: tb/tb_spi_packet_receiver.sv
module tb_spi_packet_receiver;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       cs_n = 1'b1;
  logic [1:0] selector;
  logic [7:0] data_out;
  logic       enable, busy, pkt_done, pkt_error;

  int tests_run = 0;
  int failed    = 0;
  int en_cnt    = 0;
  int done_cnt  = 0;
  int err_cnt   = 0;

  exp_t       exp_q[$];
  logic [7:0] pkt_bytes[16];

  logic       en_prev   = 1'b0;
  logic [7:0] data_prev = 8'h00;
  logic [1:0] sel_prev  = 2'b00;

  spi_packet_receiver #(
    .DATA_WIDTH (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .mosi     (mosi),
    .cs_n     (cs_n),
    .selector (selector),
    .data_out (data_out),
    .enable   (enable),
    .busy     (busy),
    .pkt_done (pkt_done),
    .pkt_error(pkt_error)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: outputs sampled on the falling clk edge.
  always @(negedge clk) begin
    exp_t e;
    if (enable === 1'b1) begin
      en_cnt++;
      tests_run++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL unexpected_enable: got sel=%0d data=%h, expected no enable", selector, data_out);
      end else begin
        e = exp_q.pop_front();
        if (selector !== e.sel || data_out !== e.data) begin
          failed++;
          $display("FAIL enable_word: got sel=%0d data=%h, expected sel=%0d data=%h",
                   selector, data_out, e.sel, e.data);
        end
      end
      tests_run++;
      if (en_prev !== 1'b0 || data_prev !== data_out || sel_prev !== selector) begin
        failed++;
        $display("FAIL present_stable: prev cycle en=%b data=%h sel=%0d, expected en=0 data=%h sel=%0d",
                 en_prev, data_prev, sel_prev, data_out, selector);
      end
    end
    if (pkt_done === 1'b1) begin
      done_cnt++;
      tests_run++;
      if (en_prev !== 1'b1) begin
        failed++;
        $display("FAIL done_timing: enable in prior cycle=%b, expected 1", en_prev);
      end
    end
    if (pkt_error === 1'b1) err_cnt++;
    en_prev   = enable;
    data_prev = data_out;
    sel_prev  = selector;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = b[i];
      wait_clks(6);
      sclk = 1'b1;
      wait_clks(6);
      sclk = 1'b0;
    end
  endtask

  task automatic send_packet(input int n);
    cs_n = 1'b0;
    wait_clks(6);
    for (int k = 0; k < n; k++) spi_bits(pkt_bytes[k], 8);
    wait_clks(6);
    cs_n = 1'b1;
    wait_clks(10);
  endtask

  task automatic check_counts(input string name, input int en0, input int dn0, input int er0,
                              input int en_exp, input int dn_exp, input int er_exp);
    tests_run++;
    if (en_cnt - en0 !== en_exp) begin
      failed++;
      $display("FAIL %s_enables: got %0d, expected %0d", name, en_cnt - en0, en_exp);
    end
    tests_run++;
    if (done_cnt - dn0 !== dn_exp) begin
      failed++;
      $display("FAIL %s_done: got %0d, expected %0d", name, done_cnt - dn0, dn_exp);
    end
    tests_run++;
    if (err_cnt - er0 !== er_exp) begin
      failed++;
      $display("FAIL %s_error: got %0d, expected %0d", name, err_cnt - er0, er_exp);
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL %s_missing: %0d words not delivered, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    tests_run++;
    if (busy !== 1'b0) begin
      failed++;
      $display("FAIL %s_busy_end: got %b, expected 0", name, busy);
    end
  endtask

  task automatic test_reset;
    wait_clks(4);
    tests_run++;
    if ({selector, data_out, enable, busy, pkt_done, pkt_error} !== 14'h0) begin
      failed++;
      $display("FAIL reset_outputs: got sel=%0d data=%h en=%b busy=%b done=%b err=%b, expected all 0",
               selector, data_out, enable, busy, pkt_done, pkt_error);
    end
    rst = 1'b0;
    wait_clks(6);
    tests_run++;
    if (busy !== 1'b0 || pkt_error !== 1'b0) begin
      failed++;
      $display("FAIL reset_release: got busy=%b err=%b, expected 0 0", busy, pkt_error);
    end
  endtask

  task automatic test_two_words;
    int en0 = en_cnt, dn0 = done_cnt, er0 = err_cnt;
    exp_q.push_back('{2'b00, 8'hA5});
    exp_q.push_back('{2'b00, 8'h3C});
    cs_n = 1'b0;
    wait_clks(6);
    tests_run++;
    if (busy !== 1'b1) begin
      failed++;
      $display("FAIL two_words_busy: got %b, expected 1", busy);
    end
    spi_bits(8'h02, 8);
    spi_bits(8'hA5, 8);
    spi_bits(8'h3C, 8);
    wait_clks(6);
    cs_n = 1'b1;
    wait_clks(10);
    check_counts("two_words", en0, dn0, er0, 2, 1, 0);
  endtask

  task automatic test_port1;
    int en0 = en_cnt, dn0 = done_cnt, er0 = err_cnt;
    exp_q.push_back('{2'b01, 8'h7E});
    pkt_bytes[0] = 8'h41;
    pkt_bytes[1] = 8'h7E;
    send_packet(2);
    check_counts("port1", en0, dn0, er0, 1, 1, 0);
    tests_run++;
    if (selector !== 2'b01) begin
      failed++;
      $display("FAIL port1_sel_held: got %0d, expected 1", selector);
    end
  endtask

  task automatic test_bad_header;
    int en0 = en_cnt, dn0 = done_cnt, er0 = err_cnt;
    pkt_bytes[0] = 8'hC1;
    pkt_bytes[1] = 8'h55;
    pkt_bytes[2] = 8'h66;
    send_packet(3);
    check_counts("bad_header", en0, dn0, er0, 0, 0, 1);
    tests_run++;
    if (selector !== 2'b01) begin
      failed++;
      $display("FAIL bad_header_sel: got %0d, expected 1 (unchanged)", selector);
    end
  endtask

  task automatic test_abort;
    int en0 = en_cnt, dn0 = done_cnt, er0 = err_cnt;
    exp_q.push_back('{2'b00, 8'h22});
    cs_n = 1'b0;
    wait_clks(6);
    spi_bits(8'h03, 8);
    spi_bits(8'h22, 8);
    spi_bits(8'h99, 3);
    wait_clks(3);
    cs_n = 1'b1;
    wait_clks(10);
    check_counts("abort", en0, dn0, er0, 1, 0, 1);
    en0 = en_cnt; dn0 = done_cnt; er0 = err_cnt;
    exp_q.push_back('{2'b00, 8'h11});
    pkt_bytes[0] = 8'h01;
    pkt_bytes[1] = 8'h11;
    send_packet(2);
    check_counts("after_abort", en0, dn0, er0, 1, 1, 0);
  endtask

  task automatic test_reset_mid;
    int en0 = en_cnt, dn0 = done_cnt, er0 = err_cnt;
    cs_n = 1'b0;
    wait_clks(6);
    spi_bits(8'h41, 8);
    spi_bits(8'hB0, 2);
    mosi = 1'b1;
    wait_clks(6);
    sclk = 1'b1;
    wait_clks(2);
    rst = 1'b1;
    #1;
    tests_run++;
    if ({selector, data_out, enable, busy, pkt_done, pkt_error} !== 14'h0) begin
      failed++;
      $display("FAIL reset_mid_outputs: got sel=%0d data=%h en=%b busy=%b done=%b err=%b, expected all 0",
               selector, data_out, enable, busy, pkt_done, pkt_error);
    end
    sclk = 1'b0;
    wait_clks(4);
    rst = 1'b0;
    wait_clks(8);
    tests_run++;
    if (busy !== 1'b0) begin
      failed++;
      $display("FAIL reset_mid_idle: got busy=%b, expected 0", busy);
    end
    cs_n = 1'b1;
    wait_clks(10);
    check_counts("reset_mid", en0, dn0, er0, 0, 0, 0);
    en0 = en_cnt; dn0 = done_cnt; er0 = err_cnt;
    exp_q.push_back('{2'b01, 8'hFF});
    pkt_bytes[0] = 8'h41;
    pkt_bytes[1] = 8'hFF;
    send_packet(2);
    check_counts("after_reset", en0, dn0, er0, 1, 1, 0);
  endtask

  task automatic test_extra_words;
    int en0 = en_cnt, dn0 = done_cnt, er0 = err_cnt;
    exp_q.push_back('{2'b00, 8'h10});
    pkt_bytes[0] = 8'h01;
    pkt_bytes[1] = 8'h10;
    pkt_bytes[2] = 8'h20;
    pkt_bytes[3] = 8'h30;
    send_packet(4);
    check_counts("extra_words", en0, dn0, er0, 1, 1, 0);
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_port1();
    test_bad_header();
    test_abort();
    test_reset_mid();
    test_extra_words();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/spi_packet_receiver.md
# spi_packet_receiver

- Ingress stage of the router: a synchronous SPI slave.
- Deserializes MOSI bytes and decodes a one-byte packet header (destination + length).
- Presents each payload word with a held destination selector and a one-cycle enable strobe to the port demultiplexer stage directly downstream.
- Detects malformed or aborted packets and drops them; nothing for a dropped word reaches the demultiplexer.

## Interface
- DATA_WIDTH, 8: word width and shift-register width; must be ≥ 8; header fields sit in the first word.
- SYNC_STAGES, 2: flip-flop depth of the sclk/mosi/cs_n synchronizers; must be ≥ 2.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- sclk  in  1  SPI clock, mode 0 (idle low, MOSI sampled on rising sclk); asynchronous to clk.
- mosi  in  1  serial data, MSB first.
- cs_n  in  1  active-low chip select; frames one packet.
- selector  out  2  destination port (header bits [DATA_WIDTH-1:DATA_WIDTH-2]); held for the whole packet.
- data_out  out  DATA_WIDTH  current payload word.
- enable  out  1  one-clk pulse; its rising edge is where the demultiplexer samples selector/data_out.
- busy  out  1  high from cs_n falling (synchronized) until packet end/abort.
- pkt_done  out  1  one-clk pulse after the last payload word of a valid packet.
- pkt_error  out  1  one-clk pulse on any drop (bad header, early cs_n rise, overrun).

## Operation
- Synchronize sclk, mosi and cs_n through SYNC_STAGES flops.
- Detect a sclk rising edge as sync_prev=0, sync_now=1. On each detected edge, shift mosi into the shift register (MSB first) and increment the bit counter.
- A word is complete when the bit counter wraps at DATA_WIDTH.
- FSM states: IDLE, HEADER, PAYLOAD, PRESENT, STROBE, DRAIN.
  - IDLE: synchronized cs_n falls → HEADER; bit counter cleared; busy=1.
  - HEADER: on word complete, decode the header.
    - Header layout: dest = [DATA_WIDTH-1:DATA_WIDTH-2]; len = [3:0].
    - Valid header: dest ∈ {00, 01} and len ≠ 0. Latch selector = dest and remaining count = len, then → PAYLOAD.
    - Otherwise: pulse pkt_error → DRAIN.
  - PAYLOAD: on word complete, load data_out with the received word → PRESENT.
  - PRESENT: one cycle; data_out and selector are stable → STROBE.
  - STROBE: enable=1 for exactly this cycle; decrement count.
    - Count reaches 0: pulse pkt_done → DRAIN.
    - Otherwise → PAYLOAD.
  - DRAIN: ignore bits until synchronized cs_n is high → IDLE; busy=0.
- Synchronized cs_n rising in HEADER, PAYLOAD, PRESENT or STROBE: pkt_error pulse → IDLE.
  - An in-flight word is discarded; no enable is issued for it.
  - If cs_n rises in STROBE, the enable for that word still completes; pkt_error is then raised only if count > 1.
- Overrun: a second word completes while in PRESENT or STROBE → pkt_error, → DRAIN. A correct sclk rate makes this impossible.
- Extra words beyond len: ignored in DRAIN; no error.
- selector changes only in HEADER; it keeps its last value in IDLE.
- Reset values: selector=0, data_out=0, enable=0, busy=0, pkt_done=0, pkt_error=0; FSM=IDLE; counters=0.

## Timing
- Let N be the clk cycle in which the last bit's synchronized sclk edge is detected.
  - data_out valid at N+1.
  - enable high during N+2 only.
  - pkt_done coincides with the last enable's following cycle (N+3).
- Input-to-detection latency is SYNC_STAGES+1 clk cycles.
- sclk high and low phases must each be ≥ SYNC_STAGES+2 clk periods; clk ≥ 8× sclk frequency is guaranteed by the system.
- cs_n must fall ≥ SYNC_STAGES+1 clk cycles before the first sclk rising edge.
- Asynchronous rst mid-packet: all outputs go to reset values immediately. The remainder of the packet is treated as DRAIN-free: after reset the FSM waits in IDLE for a fresh cs_n falling edge.
- Simultaneous cs_n rise and word completion in the same cycle: abort takes priority; the word is dropped.

## Structure
- Shared router package holds:
  - port encodings PORT0=2'b00, PORT1=2'b01;
  - header field positions (DEST_MSB offset, LEN field [3:0]);
  - FSM state encoding.
- One sub-module: spi_sync_edge. It contains the SYNC_STAGES synchronizer for sclk/mosi/cs_n and outputs sclk_rise, cs_fall, cs_rise and mosi_s.
- Everything else (shift register, counters, FSM) lives in the top module.

## Test plan
- Header 8'h02, payload 8'hA5, 8'h3C → two enable pulses with selector=00 and data_out=A5 then 3C; pkt_done once; pkt_error never.
- Header 8'h41, payload 8'h7E → one enable with selector=01 and data_out=7E; data_out stable one cycle before and during enable.
- Header 8'hC1 (dest=11) → pkt_error pulse; no enable; following bytes ignored until cs_n high.
- Header 8'h03, one payload byte, then cs_n rises mid-second byte → exactly one enable; pkt_error pulse; busy low; next packet 8'h01, 8'h11 received correctly.
- Assert rst during the third bit of a payload byte → all outputs 0 within the same cycle; next full packet 8'h41, 8'hFF → enable with data_out=FF.
- Header 8'h01 followed by three payload bytes → one enable only; pkt_done once; no pkt_error.
